xbar_switch_alloc: RTL and testbench
====================================

Name: xbar_switch_alloc

Overview:
- Per-output round-robin switch allocator that sequences the `crossbar_rr` datapath for packet (wormhole) traffic.
- Each input presents a destination request; each output owns an independent arbiter.
- Once an output grants an input, it stays locked to that input until the tail flit transfers.
- Outputs drive the crossbar select lines and per-input flit-accept strobes.

Parameters:
- PORTS, 4, number of crossbar inputs and outputs (≥2).
- IDX_W, $clog2(PORTS), width of port indices (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_i[PORTS]  input  1  input i holds a valid flit.
- dest_i[PORTS]  input  IDX_W  destination output of input i's head flit; sampled only in IDLE arbitration.
- last_i[PORTS]  input  1  input i's current flit is the packet tail.
- ready_i[PORTS]  input  1  output o can accept a flit this cycle (downstream backpressure).
- sel_o[PORTS]  output  IDX_W  input index routed to output o.
- sel_valid_o[PORTS]  output  1  output o is locked and sel_o[o] is meaningful.
- grant_o[PORTS]  output  1  input i's flit transfers this cycle; pop the flit.

Behaviour:
- Per-output state: one of IDLE or BUSY; owner[o] (IDX_W); rr pointer ptr[o] (IDX_W).
- Reset: all outputs IDLE, owner=0, ptr=0.
  - While rst=1: sel_o=0, sel_valid_o=0, grant_o=0, regardless of inputs.
  - Reset mid-packet drops the lock immediately; upstream must also flush.
- IDLE, output o:
  - Candidates are inputs i with req_i[i]=1, dest_i[i]==o, and i not owned by another output.
  - Winner = first candidate scanning ptr[o], ptr[o]+1, … mod PORTS.
  - If a winner exists, next cycle: BUSY, owner[o]=winner, ptr[o]=(winner+1) mod PORTS.
  - No candidate: stay IDLE, ptr unchanged.
  - Arbitration costs exactly one cycle bubble: the request is seen at cycle t, sel_valid_o rises at t+1, the first grant is possible at t+1.
- BUSY, output o:
  - sel_valid_o[o]=1, sel_o[o]=owner[o].
  - Transfer when req_i[owner] & ready_i[o]; grant_o[owner]=1 that cycle (combinational from registered state and inputs).
  - Transfer with last_i[owner]=1 → IDLE next cycle, so at most one idle bubble between packets on the same output.
  - req_i[owner]=0 (upstream gap) or ready_i[o]=0: hold BUSY, no grant, lock kept.
  - dest_i[owner] is ignored while BUSY.
- Input exclusivity:
  - An input is owned by at most one output.
  - A busy input is masked from all IDLE arbiters, even if its dest_i changes mid-packet (protocol violation; lock wins).
- Single-flit packet (req with last on head): IDLE→BUSY→IDLE, one grant, 2-cycle occupancy.
- Simultaneous events:
  - A release at cycle t and a new request for the same output at t: the new request is arbitrated at t+1 (the IDLE cycle).
  - Different outputs arbitrate fully in parallel in the same cycle.
- grant_o[i] is one-hot-per-input by construction. An assertion checks that no two outputs have equal owner while both are BUSY.
- Index arithmetic is mod PORTS. PORTS need not be a power of two; pointer wrap must compare against PORTS-1, not rely on overflow.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with req_i all 1 → sel_valid_o=0, grant_o=0. After release with all req_i=0 → outputs remain 0.
- Contention + fairness:
  - Stimulus: inputs 0 and 1 both request dest 3, single-flit packets, ready_i=1, requests held.
  - Required: grant sequence in0, in1, in0, in1…; sel_o[3] alternates 0,1; ptr[3] wraps 3→0 correctly. Repeat with all 4 inputs → strict 0,1,2,3 rotation.
- Wormhole lock:
  - Stimulus: input 2 sends a 4-flit packet to output 1 (last on flit 4) while input 0 requests output 1 from cycle 2.
  - Required: output 1 stays owned by 2 for all 4 flits, and input 0 gets its first grant exactly 2 cycles after in2's tail grant.
- Backpressure/gaps:
  - Stimulus: during a 3-flit packet, ready_i[o]=0 for 3 cycles, then req_i[owner]=0 for 2 cycles.
  - Required: no grant in those cycles; sel_valid_o stays 1; packet completes afterwards with exactly 3 grants total.
- Parallel paths:
  - Stimulus: inputs 0→2, 1→3, 2→0, 3→1 simultaneously.
  - Required: all four outputs BUSY in the same cycle, each with its correct sel_o, and four grants per cycle while ready.
- Mid-packet reset: rst=1 during flit 2 of a packet → next cycle all sel_valid_o=0. After release, the same input re-arbitrates from ptr=0.

Source files
------------

// File: rtl/xbar_switch_alloc.sv
// Per-output round-robin switch allocator with wormhole locking for a PORTS x PORTS crossbar.
// Latency: one arbitration cycle (request at t, lock and first possible grant at t+1); grants are combinational.
// Backpressure: a locked output holds its owner with no grant while ready_i[o]=0 or req_i[owner]=0.
module xbar_switch_alloc #(
  parameter  int PORTS = 4,
  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] req_i,
  input  logic [IDX_W-1:0] dest_i      [PORTS],
  input  logic [PORTS-1:0] last_i,
  input  logic [PORTS-1:0] ready_i,
  output logic [IDX_W-1:0] sel_o       [PORTS],
  output logic [PORTS-1:0] sel_valid_o,
  output logic [PORTS-1:0] grant_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e           state_q [PORTS];
  state_e           state_d [PORTS];
  logic [IDX_W-1:0] owner_q [PORTS];
  logic [IDX_W-1:0] owner_d [PORTS];
  logic [IDX_W-1:0] ptr_q   [PORTS];
  logic [IDX_W-1:0] ptr_d   [PORTS];

  logic [PORTS-1:0] owned;
  logic [PORTS-1:0] xfer;
  logic             owner_clash;

  // Inputs currently locked by any output; these are hidden from every idle arbiter.
  always_comb begin
    owned = '0;
    for (int o = 0; o < PORTS; o++) begin
      if (state_q[o] == BUSY) owned[owner_q[o]] = 1'b1;
    end
  end

  // Flit transfer per output and the matching per-input pop strobe.
  always_comb begin
    xfer    = '0;
    grant_o = '0;
    for (int o = 0; o < PORTS; o++) begin
      if (!rst && state_q[o] == BUSY && req_i[owner_q[o]] && ready_i[o]) begin
        xfer[o]             = 1'b1;
        grant_o[owner_q[o]] = 1'b1;
      end
    end
  end

  // Crossbar select lines straight from the locked state; forced quiet during reset.
  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      sel_valid_o[o] = !rst && (state_q[o] == BUSY);
      sel_o[o]       = (!rst && state_q[o] == BUSY) ? owner_q[o] : '0;
    end
  end

  // Next state: busy outputs release on a tail transfer, idle outputs scan from their rr pointer.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    int               idx_i;
    int               win_i;
    found = 1'b0;
    idx   = '0;
    idx_i = 0;
    win_i = 0;
    for (int o = 0; o < PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      found      = 1'b0;
      win_i      = 0;
      if (state_q[o] == BUSY) begin
        if (xfer[o] && last_i[owner_q[o]]) state_d[o] = IDLE;
      end else begin
        for (int k = 0; k < PORTS; k++) begin
          // Explicit wrap so non-power-of-two PORTS never relies on overflow.
          idx_i = int'(ptr_q[o]) + k;
          if (idx_i >= PORTS) idx_i = idx_i - PORTS;
          idx = IDX_W'(idx_i);
          if (!found && req_i[idx] && dest_i[idx] == IDX_W'(o) && !owned[idx]) begin
            found = 1'b1;
            win_i = idx_i;
          end
        end
        if (found) begin
          state_d[o] = BUSY;
          owner_d[o] = IDX_W'(win_i);
          ptr_d[o]   = (win_i == PORTS - 1) ? '0 : IDX_W'(win_i + 1);
        end
      end
    end
  end

  // Per-output state registers; reset drops every lock at once.
  always_ff @(posedge clk) begin
    for (int o = 0; o < PORTS; o++) begin
      if (rst) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end else begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

  // Two busy outputs sharing an owner would mean one input feeds two outputs.
  always_comb begin
    owner_clash = 1'b0;
    for (int a = 0; a < PORTS; a++) begin
      for (int b = a + 1; b < PORTS; b++) begin
        if (state_q[a] == BUSY && state_q[b] == BUSY && owner_q[a] == owner_q[b]) owner_clash = 1'b1;
      end
    end
  end

  // Input exclusivity check on every active cycle.
  always_ff @(posedge clk) begin
    if (!rst) assert (!owner_clash);
  end

endmodule

// File: tb/tb_xbar_switch_alloc.sv
// Scoreboard bench for xbar_switch_alloc: directed stimulus queues expected grants, a monitor checks them.
// Grants are checked at the falling edge against the cycle, input and output the stimulus predicted.
// Inputs are driven 1 time unit after the rising edge.
module tb_xbar_switch_alloc;

  localparam int P = 4;

  logic         clk;
  logic         rst;
  logic [P-1:0] req;
  logic [1:0]   dest [P];
  logic [P-1:0] last;
  logic [P-1:0] ready;
  logic [1:0]   sel  [P];
  logic [P-1:0] selv;
  logic [P-1:0] gnt;

  typedef struct {
    int cyc;
    int inp;
    int outp;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   t0;

  xbar_switch_alloc #(.PORTS(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .dest_i     (dest),
    .last_i     (last),
    .ready_i    (ready),
    .sel_o      (sel),
    .sel_valid_o(selv),
    .grant_o    (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input int i, input int o);
    exp_t e;
    e.cyc  = c;
    e.inp  = i;
    e.outp = o;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int req_v);
    total++;
    if (act != req_v) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, req_v);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req   = '0;
    last  = '0;
    ready = '1;
    for (int i = 0; i < P; i++) dest[i] = 2'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    next();
    next();
    rst = 1'b0;
    next();
  endtask

  // Monitor: every grant must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_grant cyc=%0d got=none want=in%0d->out%0d at cyc %0d", cyc, e.inp, e.outp, e.cyc);
    end
    for (int i = 0; i < P; i++) begin
      if (gnt[i]) begin
        total++;
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          if (e.inp != i || !selv[e.outp] || int'(sel[e.outp]) != i) begin
            bad++;
            $display("FAIL grant cyc=%0d got=in%0d (out%0d selv=%0b sel=%0d) want=in%0d->out%0d",
                     cyc, i, e.outp, selv[e.outp], sel[e.outp], e.inp, e.outp);
          end
        end else begin
          bad++;
          $display("FAIL unexpected_grant cyc=%0d got=in%0d want=no grant", cyc, i);
        end
      end
    end
  end

  initial begin
    clear_inputs();
    rst = 1'b1;

    // Reset with every input requesting: nothing may be selected or granted.
    req = 4'hf;
    next();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_selv", int'(selv), 0);
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_sel3", int'(sel[3]), 0);
      next();
    end
    rst = 1'b0;
    req = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_selv", int'(selv), 0);
      chk("idle_gnt", int'(gnt), 0);
      next();
    end

    // Two inputs contend for output 3 with single-flit packets.
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 16; k++) begin
      req = 4'b0011; last = 4'hf; dest[0] = 2'd3; dest[1] = 2'd3;
      if (k % 2 == 1) push(t0 + k, (k / 2) % 2, 3);
      next();
    end
    req = '0;
    next(); next();

    // All four inputs contend for output 3: strict rotation with pointer wrap.
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 16; k++) begin
      req = 4'hf; last = 4'hf;
      for (int i = 0; i < P; i++) dest[i] = 2'd3;
      if (k % 2 == 1) push(t0 + k, (k / 2) % 4, 3);
      next();
    end
    req = '0;
    next(); next();

    // Wormhole: input 2 holds output 1 for 4 flits while input 0 waits.
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 9; k++) begin
      req = '0; last = '0; dest[0] = 2'd1; dest[2] = 2'd1;
      req[2]  = (k <= 4);
      last[2] = (k == 4);
      req[0]  = (k >= 2 && k <= 6);
      last[0] = 1'b1;
      if (k >= 1 && k <= 4) push(t0 + k, 2, 1);
      if (k == 6) push(t0 + k, 0, 1);
      if (k == 5) begin
        @(negedge clk);
        chk("worm_bubble_selv1", int'(selv[1]), 0);
      end
      next();
    end

    // Backpressure then upstream gap inside a 3-flit packet from input 1 to output 0.
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 11; k++) begin
      req = '0; last = '0; ready = '1; dest[1] = 2'd0;
      req[1]   = (k <= 4) || (k == 7) || (k == 8);
      last[1]  = (k == 8);
      ready[0] = !(k >= 2 && k <= 4);
      if (k == 1 || k == 7 || k == 8) push(t0 + k, 1, 0);
      if (k >= 2 && k <= 6) begin
        @(negedge clk);
        chk("bp_selv0", int'(selv[0]), 1);
        chk("bp_sel0", int'(sel[0]), 1);
      end
      next();
    end
    ready = '1;

    // Four disjoint paths in parallel, 3 flits each.
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 6; k++) begin
      dest[0] = 2'd2; dest[1] = 2'd3; dest[2] = 2'd0; dest[3] = 2'd1;
      req  = (k <= 3) ? 4'hf : 4'h0;
      last = (k == 3) ? 4'hf : 4'h0;
      if (k >= 1 && k <= 3) begin
        push(t0 + k, 0, 2);
        push(t0 + k, 1, 3);
        push(t0 + k, 2, 0);
        push(t0 + k, 3, 1);
      end
      if (k == 1) begin
        @(negedge clk);
        chk("par_selv", int'(selv), 15);
        chk("par_sel0", int'(sel[0]), 2);
        chk("par_sel1", int'(sel[1]), 3);
        chk("par_sel2", int'(sel[2]), 0);
        chk("par_sel3", int'(sel[3]), 1);
      end
      next();
    end

    // Reset during flit 2, then input 1 must win again from a cleared pointer.
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 9; k++) begin
      req = '0; last = '0; dest[1] = 2'd2; dest[3] = 2'd2;
      rst = (k == 2);
      if (k <= 2) req[1] = 1'b1;
      if (k >= 3) begin
        req[1]  = (k <= 4);
        req[3]  = (k <= 6);
        last[1] = 1'b1;
        last[3] = 1'b1;
      end
      if (k == 1) push(t0 + k, 1, 2);
      if (k == 4) push(t0 + k, 1, 2);
      if (k == 6) push(t0 + k, 3, 2);
      if (k == 2 || k == 3) begin
        @(negedge clk);
        chk("mid_rst_selv", int'(selv), 0);
        chk("mid_rst_sel2", int'(sel[2]), 0);
      end
      next();
    end
    rst = 1'b0;
    req = '0;
    next(); next();

    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
